// File: rtl/irq_event_ctrl.sv
// +----------------------------------------------------------------------------+
// | irq_event_ctrl: APB-programmed interrupt and wake-event controller         |
// | Edge-detected IRQ/event pending bits, priority IRQ request, wake signal.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_event_ctrl #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [31:0]               irq_lines_i,
  input  logic [31:0]               evt_lines_i,
  input  logic                      irq_ack_i,
  output logic                      irq_req_o,
  output logic [4:0]                irq_id_o,
  output logic                      signal_o
);

  localparam logic [2:0] C_IRQ_MASK    = 3'd0;
  localparam logic [2:0] C_IRQ_PENDING = 3'd1;
  localparam logic [2:0] C_IRQ_SET     = 3'd2;
  localparam logic [2:0] C_IRQ_CLEAR   = 3'd3;
  localparam logic [2:0] C_EVT_MASK    = 3'd4;
  localparam logic [2:0] C_EVT_PENDING = 3'd5;
  localparam logic [2:0] C_EVT_CLEAR   = 3'd6;

  logic [31:0] irq_prev_q, irq_prev_d;
  logic [31:0] evt_prev_q, evt_prev_d;
  logic [31:0] irq_mask_q, irq_mask_d;
  logic [31:0] evt_mask_q, evt_mask_d;
  logic [31:0] irq_pend_q, irq_pend_d;
  logic [31:0] evt_pend_q, evt_pend_d;
  logic        irq_req_q, irq_req_d;
  logic [4:0]  irq_id_q, irq_id_d;
  logic        signal_q, signal_d;

  logic [2:0]  reg_idx;
  logic        wr_en;
  logic        rd_en;
  logic        ack_valid;
  logic [31:0] irq_set;
  logic [31:0] irq_clr;
  logic [31:0] evt_set;
  logic [31:0] evt_clr;
  logic [31:0] irq_active;
  logic [4:0]  lowest_idx;
  logic        unused_paddr;

  assign reg_idx      = PADDR[4:2];
  assign wr_en        = PSEL && PENABLE && PWRITE;
  assign rd_en        = PSEL && PENABLE && !PWRITE;
  assign ack_valid    = irq_ack_i && irq_req_q;
  assign unused_paddr = ^PADDR;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  always_comb begin
    PRDATA = 32'h0;
    if (rd_en) begin
      case (reg_idx)
        C_IRQ_MASK:    PRDATA = irq_mask_q;
        C_IRQ_PENDING: PRDATA = irq_pend_q;
        C_EVT_MASK:    PRDATA = evt_mask_q;
        C_EVT_PENDING: PRDATA = evt_pend_q;
        default:       PRDATA = 32'h0;
      endcase
    end
  end

  // Set sources are OR-ed in after clears so a same-cycle set always wins.
  always_comb begin
    irq_set = irq_lines_i & ~irq_prev_q;
    evt_set = evt_lines_i & ~evt_prev_q;
    irq_clr = 32'h0;
    evt_clr = 32'h0;
    if (wr_en && reg_idx == C_IRQ_SET)   irq_set = irq_set | PWDATA;
    if (wr_en && reg_idx == C_IRQ_CLEAR) irq_clr = PWDATA;
    if (wr_en && reg_idx == C_EVT_CLEAR) evt_clr = PWDATA;
    if (ack_valid)                       irq_clr = irq_clr | (32'h1 << irq_id_q);

    irq_pend_d = (irq_pend_q & ~irq_clr) | irq_set;
    evt_pend_d = (evt_pend_q & ~evt_clr) | evt_set;
    irq_prev_d = irq_lines_i;
    evt_prev_d = evt_lines_i;
    irq_mask_d = (wr_en && reg_idx == C_IRQ_MASK) ? PWDATA : irq_mask_q;
    evt_mask_d = (wr_en && reg_idx == C_EVT_MASK) ? PWDATA : evt_mask_q;
  end

  always_comb begin
    irq_active = irq_pend_q & irq_mask_q;
    lowest_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (irq_active[i]) lowest_idx = 5'(i);
    end
    irq_req_d = |irq_active;
    irq_id_d  = irq_req_d ? lowest_idx : irq_id_q;
    signal_d  = (|irq_active) | (|(evt_pend_q & evt_mask_q));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_prev_q <= 32'h0;
      evt_prev_q <= 32'h0;
      irq_mask_q <= 32'h0;
      evt_mask_q <= 32'h0;
      irq_pend_q <= 32'h0;
      evt_pend_q <= 32'h0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= 5'd0;
      signal_q   <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      evt_prev_q <= evt_prev_d;
      irq_mask_q <= irq_mask_d;
      evt_mask_q <= evt_mask_d;
      irq_pend_q <= irq_pend_d;
      evt_pend_q <= evt_pend_d;
      irq_req_q  <= irq_req_d;
      irq_id_q   <= irq_id_d;
      signal_q   <= signal_d;
    end
  end

  assign irq_req_o = irq_req_q;
  assign irq_id_o  = irq_id_q;
  assign signal_o  = signal_q;

endmodule

`default_nettype wire
